// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            producers, with full/almost_full back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          wr_en,
  input  logic                          full,
  input  logic                          almost_full,
  input  logic                          overflow,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          wr_count,
  output logic                          ovf_err
);

  localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] c_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]    r_gnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_wr_en;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_ovf_err;
  logic [c_PTR_W-1:0]    r_ptr;
  logic                  r_run;

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_found;
  logic [c_PTR_W-1:0]    w_winner;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Last cycle's winner is masked so a held req is not granted twice.
  assign w_eligible = req & ~r_gnt;

  always_comb begin
    logic [c_PTR_W-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      v_idx = c_PTR_W'((int'(r_ptr) + off) % NUM_REQ);
      if (!w_found && w_eligible[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // The almost_full term covers the write already on its way into the FIFO.
  assign w_issue = r_run && en && w_found && !full && !(almost_full && r_wr_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_data    <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
      r_ptr     <= '0;
      r_run     <= 1'b0;
    end else begin
      // First edge after reset release only arms the arbiter.
      r_run  <= 1'b1;
      r_busy <= w_issue | (|w_eligible);
      if (overflow) begin
        r_ovf_err <= 1'b1;
      end
      if (w_issue) begin
        r_gnt   <= c_ONE << w_winner;
        r_data  <= w_words[w_winner];
        r_wr_en <= 1'b1;
        r_count <= r_count + 1'b1;
        r_ptr   <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
      end else begin
        r_gnt   <= '0;
        r_wr_en <= 1'b0;
      end
    end
  end

  assign gnt      = r_gnt;
  assign data_in  = r_data;
  assign wr_en    = r_wr_en;
  assign busy     = r_busy;
  assign wr_count = r_count;
  assign ovf_err  = r_ovf_err;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter. Shares one synchronous FIFO write port (data_in/wr_en) among NUM_REQ independent producers.
- Sits directly in front of the FIFO. Drives its write side and uses the FIFO's full/almost_full/overflow flags to prevent overflow.
- The FIFO read side is untouched and is driven by the consumer as before.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, FIFO data width.
- CNT_WIDTH, 16, width of the issued-write counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable; low blocks new grants.
- req  in  NUM_REQ  per-requester write request, level.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  registered one-hot grant pulse.
- data_in  out  DATA_WIDTH  to FIFO data_in, registered.
- wr_en  out  1  to FIFO wr_en, registered.
- full  in  1  from FIFO.
- almost_full  in  1  from FIFO; high when count == DEPTH-1.
- overflow  in  1  from FIFO.
- busy  out  1  high when a grant was issued this cycle or any unmasked req is pending.
- wr_count  out  CNT_WIDTH  total writes issued since reset; wraps to 0.
- ovf_err  out  1  sticky overflow indication.

Behaviour:
- Reset (async, rst_n=0): gnt=0, wr_en=0, data_in=0, wr_count=0, ovf_err=0, busy=0, round-robin pointer=0. Any request in flight is abandoned.
- Request handshake:
  - Requester raises req[i] with stable data and holds both until it sees gnt[i]=1.
  - gnt[i] is high for exactly one cycle. The word is captured at the same edge that raises gnt[i].
  - The requester may change data or drop req in the cycle gnt[i] is high.
  - The requester granted at edge k is masked out of arbitration for edge k+1. This prevents a double grant.
- Throughput:
  - Single active requester: at most 1 write per 2 cycles.
  - Two or more active requesters: 1 write per cycle.
- Issue condition at edge k: en && |eligible && !full && !(almost_full && wr_en). Here eligible = req & ~gnt, and wr_en is the current registered value.
  - The almost_full term accounts for the write already in flight. An issued write can never hit a full FIFO.
- Winner selection:
  - Winner = first eligible index searching upward from ptr, wrapping NUM_REQ-1 -> 0.
  - On issue: ptr <= (winner+1) mod NUM_REQ, gnt <= onehot(winner), data_in <= req_data slice of winner, wr_en <= 1, wr_count <= wr_count+1.
  - On no issue: gnt <= 0, wr_en <= 0; data_in and ptr hold.
- Latency: req sampled at edge k -> gnt and wr_en high in cycle k..k+1 -> FIFO stores the word at edge k+1.
- Stall handling: while stalled by full, almost_full or en=0, requests stay pending. No grant is lost and no data is dropped. Priority is preserved because ptr does not move.
- Simultaneous requests: the pointer rotation guarantees every continuously asserted requester is granted within NUM_REQ issue slots.
- en falling mid-stream: a write already registered still completes. No new grants are issued from the next edge.
- ovf_err: set when overflow=1 at a rising edge; cleared only by reset. It must never set under correct FIFO behaviour. The bench checks this.
- wr_count: wraps modulo 2^CNT_WIDTH with no saturation.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with req=4'b1111 -> gnt=0, wr_en=0, wr_count=0 immediately. First grant goes to requester 0 two edges after rst_n rises.
- Round-robin fairness: req=4'b1111 held, en=1, FIFO never full -> grant order 0,1,2,3,0,... with wr_en=1 every cycle. After 8 cycles wr_count=8.
- Single requester: only req[2]=1, data 16'hA5A5 then 16'hA5A6 -> gnt[2] pulses every other cycle. FIFO receives A5A5, A5A6 in order with no duplicates.
- Full back-pressure: FIFO DEPTH=8, no reads, req=4'b0011 -> exactly 8 writes issued; wr_en stays 0 while full=1. Then read 1 word -> exactly one further grant. Grant goes to the requester next after the last winner. ovf_err stays 0.
- almost_full boundary: count=7, wr_en=1 in flight -> no grant at that edge. Next grant only after a read frees space.
- en toggle: en=0 for 5 cycles with req=4'b1000 pending -> no gnt. en=1 -> gnt[3] on the next edge with the held data.
